// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the loadable instruction memory
package proc_pkg;
    localparam int DBITS     = 32;
    localparam int INST_SIZE = 4;
    localparam logic [DBITS-1:0] START_PC = '0;

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD, RUN} state_e;

    localparam logic [1:0] FC_NONE           = 2'd0;
    localparam logic [1:0] FC_LOAD_BAD_ADDR  = 2'd1;
    localparam logic [1:0] FC_FETCH_MISALIGN = 2'd2;
    localparam logic [1:0] FC_FETCH_RANGE    = 2'd3;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port RAM with synchronous write and registered read
module imem_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // write the addressed word and register the old contents as read data
    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory with zero-fill, loader port and faulting fetch
module imem_loadable #(
    parameter int DBITS               = proc_pkg::DBITS,
    parameter int IMEM_ADDR_BIT_WIDTH = 11,
    parameter int IMEM_PC_BITS_LO     = 2,
    parameter int IMEM_PC_BITS_HI     = IMEM_ADDR_BIT_WIDTH + IMEM_PC_BITS_LO
) (
    input  logic                         CLOCK_50,
    input  logic                         FPGA_RESET_N,
    input  logic                         ld_start,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [DBITS-1:0]             ld_addr,
    input  logic [DBITS-1:0]             ld_data,
    input  logic                         ld_end,
    output logic                         core_reset_n,
    input  logic [DBITS-1:0]             pc,
    input  logic                         fetch_en,
    output logic [DBITS-1:0]             inst_word,
    output logic                         inst_valid,
    output logic                         fault,
    output logic [1:0]                   fault_code,
    output logic [IMEM_ADDR_BIT_WIDTH:0] load_count
);
    import proc_pkg::*;

    localparam int AW = IMEM_ADDR_BIT_WIDTH;
    localparam int LO = IMEM_PC_BITS_LO;
    localparam int HI = IMEM_PC_BITS_HI;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             crst_q, valid_q, ok_q;
    logic [DBITS-1:0] word_q, word_d;
    logic             hs, ld_legal, mis, rng, fetch, bad;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DBITS-1:0] ram_wdata, ram_rdata;

    assign hs       = state_q == LOAD && ld_valid;
    assign ld_legal = ld_addr[LO-1:0] == '0 && ld_addr[DBITS-1:HI] == '0;
    assign mis      = |pc[LO-1:0];
    assign rng      = |pc[DBITS-1:HI];
    assign fetch    = state_q == RUN && fetch_en && !ld_start;
    assign bad      = fetch && (mis || rng);

    // only one of CLEAR, LOAD and RUN drives the single RAM port at a time
    assign ram_we    = state_q == CLEAR || (hs && ld_legal);
    assign ram_addr  = state_q == CLEAR ? ptr_q : state_q == LOAD ? ld_addr[HI-1:LO] : pc[HI-1:LO];
    assign ram_wdata = state_q == CLEAR ? '0 : ld_data;

    imem_ram #(.AW(AW), .DW(DBITS)) u_ram (
        .clk_i   (CLOCK_50),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // sequencing, load counter and first-fault capture
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) state_d = IDLE;
            end
            IDLE:    if (ld_start) state_d = LOAD;
            LOAD:    if (ld_end && !ld_start) state_d = RUN;
            RUN:     if (ld_start) state_d = LOAD;
            default: state_d = CLEAR;
        endcase
        if (hs && ld_legal && count_q != FULL) count_d = count_q + 1'b1;
        if (!fault_q && ((hs && !ld_legal) || bad)) begin
            fault_d = 1'b1;
            code_d  = hs ? FC_LOAD_BAD_ADDR : mis ? FC_FETCH_MISALIGN : FC_FETCH_RANGE;
        end
        if (state_q != CLEAR && ld_start) begin
            count_d = '0;
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
    end

    // a faulting fetch forces zero; a good fetch latches RAM data for holding
    assign word_d = bad ? '0 : ok_q ? ram_rdata : word_q;

    // state registers with asynchronous reset into CLEAR
    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            crst_q  <= 1'b0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            crst_q  <= state_d == RUN;
            valid_q <= fetch;
            ok_q    <= fetch && !(mis || rng);
            word_q  <= word_d;
        end
    end

    assign ld_ready     = state_q == LOAD;
    assign core_reset_n = crst_q;
    assign inst_word    = ok_q ? ram_rdata : word_q;
    assign inst_valid   = valid_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign load_count   = count_q;
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory with a loader front-end and run/load sequencing, replacing the ad-hoc instruction array driven by the processor bench. After reset it zero-fills memory, then accepts a program over a valid/ready load port. On load end it releases the core from reset and serves registered fetches from a byte-addressed PC. Misaligned and out-of-range accesses are flagged as faults rather than silently aliased.

Parameters:
DBITS, 32, data and address width in bits
IMEM_ADDR_BIT_WIDTH, 11, log2 of memory depth in words
IMEM_PC_BITS_LO, 2, log2 of instruction size in bytes; PC low bits that must be zero
IMEM_PC_BITS_HI, IMEM_ADDR_BIT_WIDTH+IMEM_PC_BITS_LO, PC bit just above the word index

Ports:
CLOCK_50  in  1  clock; all state changes on rising edge
FPGA_RESET_N  in  1  asynchronous, active-low reset
ld_start  in  1  pulse: enter LOAD, clear load_count and fault
ld_valid  in  1  load word present
ld_ready  out  1  high only in LOAD
ld_addr  in  DBITS  byte address of the load word
ld_data  in  DBITS  instruction word
ld_end  in  1  pulse: finish the load and enter RUN
core_reset_n  out  1  active-low core reset; high only while in RUN
pc  in  DBITS  fetch byte address
fetch_en  in  1  fetch request
inst_word  out  DBITS  fetched instruction
inst_valid  out  1  inst_word valid this cycle
fault  out  1  sticky fault flag
fault_code  out  2  0 NONE, 1 LOAD_BAD_ADDR, 2 FETCH_MISALIGN, 3 FETCH_RANGE
load_count  out  IMEM_ADDR_BIT_WIDTH+1  number of words accepted since the last ld_start

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear pointer=0. All outputs 0: ld_ready, core_reset_n, inst_word, inst_valid, fault, fault_code, load_count.
- CLEAR: writes 0 to word[ptr] each cycle and increments ptr. After the last word (2^AW cycles) it goes to IDLE. ld_start, ld_valid and fetch_en are ignored.
- IDLE: ld_start goes to LOAD. fetch_en is ignored.
- LOAD: ld_ready=1. A handshake occurs when ld_valid&&ld_ready.
  - Address legal when ld_addr[LO-1:0]==0 and ld_addr[DBITS-1:HI]==0. A legal word writes mem[ld_addr[HI-1:LO]] and increments load_count, which saturates at 2^AW.
  - An illegal address drops the word, sets fault with code 1, and the state stays LOAD.
  - ld_end goes to RUN. If ld_end and a handshake occur in the same cycle, the word is written first.
  - ld_start while in LOAD restarts: load_count=0, fault cleared, memory kept.
- RUN: core_reset_n is a registered output, high from the first cycle after entering RUN.
  - fetch_en at cycle N: at N+1 inst_word=mem[pc[HI-1:LO]], inst_valid=1. Without fetch_en, inst_valid=0 next cycle and inst_word holds its value.
  - pc[LO-1:0]!=0: inst_word=0, inst_valid=1, fault code 2.
  - pc[DBITS-1:HI]!=0: inst_word=0, inst_valid=1, fault code 3.
  - When both fetch faults apply, misalign (code 2) has priority.
  - ld_start goes to LOAD. core_reset_n=0 and inst_valid=0 from the next cycle.
- Fault is sticky: the first code is kept until ld_start or reset; later faults do not overwrite it.
- Reset mid-LOAD or mid-RUN returns to CLEAR; any partially loaded program is zeroed.
- Memory read is synchronous; no combinational path from pc to inst_word.

Decomposition:
- Shared package proc_pkg:
  - state enum CLEAR/IDLE/LOAD/RUN
  - fault code constants
  - DBITS, INST_SIZE, START_PC defaults
- One sub-module, imem_ram: single port, synchronous write, synchronous read, parametrised by depth and width.
- Mux CLEAR, LOAD and RUN access onto that single port. Only one of these states is active at any time, so there is no contention.

Test Plan:
- Reset released, then count cycles → IDLE reached after exactly 2048 CLEAR cycles; all outputs 0; core_reset_n=0 throughout.
- ld_start; load 0x2f000000@0x40 and 0xfbf00001@0x44; ld_end; fetch pc=0x44 → one cycle later inst_word=0xfbf00001, inst_valid=1, load_count=2, core_reset_n=1.
- In LOAD, send ld_addr=0x42, then ld_addr=0x2000 → both words dropped; fault=1, fault_code=1 (first kept); load_count unchanged; ld_start clears fault.
- In RUN, fetch pc=0x41 then pc=0x4000 → inst_word=0 both times; fault_code=2 sticky; repeat after ld_start with pc=0x4000 only → fault_code=3.
- ld_end asserted together with a handshake of 0x8000021@0x4C → word is written; fetch 0x4C returns 0x8000021.
- Assert FPGA_RESET_N low mid-RUN → outputs 0 immediately; after CLEAR, reload without address 0x40 → fetch 0x40 returns 0.
